uart_tx_sched: RTL and testbench

- Schedules and shares the UART transmitter between two requesters.
  - The CPU store path: memory-mapped byte writes, fire-and-forget.
  - A monitor/debug port: valid/ready handshake, e.g. hardware-counter dumps.
- Sits between the memory block's UART write strobe/data and the uart transmitter's write-strobe/data inputs.
- The transmitter exposes no busy flag, so this block buffers CPU bytes in a FIFO and paces issues with a character-time counter.

---
 rtl/uart_tx_sched.sv | 212 +++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//
// Shares a single UART transmitter between two requesters:
//   * the CPU store path, which pushes bytes fire-and-forget into a small FIFO;
//   * a monitor/debug port using a valid/ready handshake.
// The transmitter has no busy flag, so after every issued character this block
// reserves CHAR_CYCLES clocks (the GAP state) before it grants again.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active-high
//   tx_en       1 = new grants allowed; 0 = hold once the in-flight char ends
//   cpu_we      single-cycle CPU push strobe
//   cpu_data    byte pushed with cpu_we
//   mon_valid   monitor request, held until mon_ready
//   mon_data    monitor byte, stable while mon_valid=1
//   mon_ready   one-cycle acknowledge: monitor byte taken
//   uart_wr_o   one-cycle write strobe to the transmitter
//   uart_dat_o  byte to the transmitter, held between strobes
//   fifo_count  CPU FIFO occupancy
//   cpu_full    fifo_count == DEPTH
//   cpu_ovf     sticky: a CPU push was dropped because the FIFO was full
//   busy        a character is in flight or a request is pending
// -----------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int DEPTH       = 8,
    parameter int CHAR_CYCLES = 8680,
    parameter int CNT_W       = 14
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     tx_en,
    input  logic                     cpu_we,
    input  logic [7:0]               cpu_data,
    input  logic                     mon_valid,
    input  logic [7:0]               mon_data,
    output logic                     mon_ready,
    output logic                     uart_wr_o,
    output logic [7:0]               uart_dat_o,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     cpu_full,
    output logic                     cpu_ovf,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_MON = 1'b1;

    localparam logic [AW:0]      FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(CHAR_CYCLES - 1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;
    logic             r_wr;
    logic [7:0]       r_dat;
    logic             r_mon_ready;

    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_count;
    logic             r_ovf;

    // -------------------------------------------------------------------------
    // Combinational decode
    // -------------------------------------------------------------------------
    logic       w_full;
    logic       w_cpu_req;
    logic       w_grant_cpu;
    logic       w_grant_mon;
    logic       w_start;
    logic       w_push;
    logic       w_pop;
    logic [7:0] w_head;

    always_comb begin
        w_full      = 1'b0;
        w_cpu_req   = 1'b0;
        w_grant_cpu = 1'b0;
        w_grant_mon = 1'b0;
        w_start     = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_head      = r_mem[r_rptr];

        // Full is judged on the registered count only, so a pop in the same
        // cycle does not open a slot for a simultaneous push.
        w_full    = (r_count == FULL_CNT);
        w_cpu_req = (r_count != '0);

        // Round-robin on a tie: the side that did not win last time goes now.
        // A lone requester always wins.
        w_grant_cpu = w_cpu_req && (!mon_valid || (r_last_grant == GRANT_MON));
        w_grant_mon = mon_valid && (!w_cpu_req || (r_last_grant == GRANT_CPU));

        // New grants only from IDLE and only while enabled.
        w_start = (r_state == ST_IDLE) && tx_en && (w_cpu_req || mon_valid);

        w_push = cpu_we && !w_full;
        w_pop  = w_start && w_grant_cpu;
    end

    // -------------------------------------------------------------------------
    // Scheduler FSM: IDLE -> SEND (strobe) -> GAP (character time) -> IDLE
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last_grant <= GRANT_MON;
            r_wr         <= 1'b0;
            r_dat        <= 8'h00;
            r_mon_ready  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wr        <= 1'b0;
                    r_mon_ready <= 1'b0;
                    if (w_start) begin
                        r_state      <= ST_SEND;
                        r_wr         <= 1'b1;
                        r_dat        <= w_grant_mon ? mon_data : w_head;
                        r_mon_ready  <= w_grant_mon;
                        r_last_grant <= w_grant_mon ? GRANT_MON : GRANT_CPU;
                    end
                end

                ST_SEND: begin
                    // Monitor may still show the same request this cycle; we
                    // leave IDLE before it could be seen again.
                    r_state     <= ST_GAP;
                    r_wr        <= 1'b0;
                    r_mon_ready <= 1'b0;
                    r_cnt       <= GAP_LOAD;
                end

                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    r_wr        <= 1'b0;
                    r_mon_ready <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // CPU FIFO control: pointers, occupancy, overflow flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase

            if (cpu_we && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // FIFO storage carries data only, so it is never reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= cpu_data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign uart_wr_o  = r_wr;
    assign uart_dat_o = r_dat;
    assign mon_ready  = r_mon_ready;
    assign fifo_count = r_count;
    assign cpu_full   = w_full;
    assign cpu_ovf    = r_ovf;
    assign busy       = (r_state != ST_IDLE) || (r_count != '0) || mon_valid;

endmodule

// File: tb/tb_uart_tx_sched.sv
module tb_uart_tx_sched;

    localparam int DEPTH = 8;
    localparam int CC    = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_en;
    logic       cpu_we;
    logic [7:0] cpu_data;
    logic       mon_valid;
    logic [7:0] mon_data;
    logic       mon_ready;
    logic       uart_wr_o;
    logic [7:0] uart_dat_o;
    logic [3:0] fifo_count;
    logic       cpu_full;
    logic       cpu_ovf;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] sdat [16];
    int         scyc [16];
    logic       smr  [16];
    int         ns;
    int         nstr;
    int         nmr;
    logic       mr_prev;

    always #5 clk = ~clk;

    uart_tx_sched #(
        .DEPTH      (DEPTH),
        .CHAR_CYCLES(CC),
        .CNT_W      (14)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_en     (tx_en),
        .cpu_we    (cpu_we),
        .cpu_data  (cpu_data),
        .mon_valid (mon_valid),
        .mon_data  (mon_data),
        .mon_ready (mon_ready),
        .uart_wr_o (uart_wr_o),
        .uart_dat_o(uart_dat_o),
        .fifo_count(fifo_count),
        .cpu_full  (cpu_full),
        .cpu_ovf   (cpu_ovf),
        .busy      (busy)
    );

    // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rst_pulse();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        tx_en     = 1'b0;
        cpu_we    = 1'b0;
        cpu_data  = 8'h00;
        mon_valid = 1'b0;
        mon_data  = 8'h00;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_wr",    uart_wr_o,  0);
        check("rst_dat",   uart_dat_o, 0);
        check("rst_mrdy",  mon_ready,  0);
        check("rst_cnt",   fifo_count, 0);
        check("rst_full",  cpu_full,   0);
        check("rst_ovf",   cpu_ovf,    0);
        check("rst_busy",  busy,       0);

        // Single CPU byte: count 1 next cycle, strobe the cycle after
        tx_en    = 1'b1;
        cpu_we   = 1'b1;
        cpu_data = 8'h41;
        step();
        cpu_we = 1'b0;
        check("t1_cnt1", fifo_count, 1);
        check("t1_nowr", uart_wr_o,  0);
        step();
        check("t1_wr",   uart_wr_o,  1);
        check("t1_dat",  uart_dat_o, 8'h41);
        check("t1_cnt0", fifo_count, 0);
        check("t1_busy", busy,       1);
        nstr = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (uart_wr_o) nstr++;
        end
        check("t1_gap_nostrobe", nstr, 0);
        check("t1_idle_busy",    busy, 0);
        check("t1_dat_hold",     uart_dat_o, 8'h41);

        // Fill FIFO with tx disabled, overflow, then drain
        tx_en = 1'b0;
        rst_pulse();
        for (int i = 0; i < 8; i++) begin
            cpu_we   = 1'b1;
            cpu_data = 8'(8'h30 + i);
            step();
            check("t2_fill_cnt", fifo_count, i + 1);
        end
        check("t2_full", cpu_full, 1);
        check("t2_ovf_before", cpu_ovf, 0);
        cpu_data = 8'h38;
        step();
        cpu_we = 1'b0;
        check("t2_ovf",      cpu_ovf,    1);
        check("t2_cnt_ovf",  fifo_count, 8);
        tx_en = 1'b1;
        ns = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (uart_wr_o && ns < 16) begin
                sdat[ns] = uart_dat_o;
                scyc[ns] = c;
                ns++;
            end
        end
        check("t2_nstrobes", ns, 8);
        for (int k = 0; k < 8; k++) begin
            check("t2_order", sdat[k], 8'(8'h30 + k));
            if (k > 0) check("t2_spacing", scyc[k] - scyc[k-1], CC + 2);
        end
        check("t2_first_lat", scyc[0], 0);
        check("t2_drained",   fifo_count, 0);
        check("t2_ovf_sticky", cpu_ovf, 1);

        // Round-robin between CPU and monitor
        tx_en = 1'b0;
        rst_pulse();
        cpu_we   = 1'b1;
        cpu_data = 8'hA0;
        step();
        cpu_data = 8'hA1;
        step();
        cpu_we    = 1'b0;
        mon_valid = 1'b1;
        mon_data  = 8'h55;
        tx_en     = 1'b1;
        ns      = 0;
        nmr     = 0;
        mr_prev = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (mr_prev) begin
                if (mon_data == 8'h55) mon_data = 8'h56;
                else mon_valid = 1'b0;
            end
            mr_prev = mon_ready;
            if (mon_ready) nmr++;
            if (uart_wr_o && ns < 16) begin
                sdat[ns] = uart_dat_o;
                smr[ns]  = mon_ready;
                ns++;
            end
        end
        check("t3_nstrobes", ns, 4);
        check("t3_s0", sdat[0], 8'hA0);
        check("t3_s1", sdat[1], 8'h55);
        check("t3_s2", sdat[2], 8'hA1);
        check("t3_s3", sdat[3], 8'h56);
        check("t3_mr0", smr[0], 0);
        check("t3_mr1", smr[1], 1);
        check("t3_mr2", smr[2], 0);
        check("t3_mr3", smr[3], 1);
        check("t3_nmr", nmr, 2);
        check("t3_busy_end", busy, 0);

        // Pop and push in the same edge while full: push is dropped
        tx_en = 1'b0;
        rst_pulse();
        for (int i = 0; i < 8; i++) begin
            cpu_we   = 1'b1;
            cpu_data = 8'(8'h10 + i);
            step();
        end
        check("t4_full", cpu_full, 1);
        cpu_data = 8'h7E;
        tx_en    = 1'b1;
        step();
        cpu_we = 1'b0;
        check("t4_wr",  uart_wr_o,  1);
        check("t4_dat", uart_dat_o, 8'h10);
        check("t4_cnt", fifo_count, 7);
        check("t4_ovf", cpu_ovf,    1);
        check("t4_notfull", cpu_full, 0);
        ns = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (uart_wr_o && ns < 16) begin
                sdat[ns] = uart_dat_o;
                ns++;
            end
        end
        check("t4_nstrobes", ns, 7);
        for (int k = 0; k < 7; k++) begin
            check("t4_order", sdat[k], 8'(8'h11 + k));
        end

        // tx_en dropped during GAP
        rst_pulse();
        tx_en    = 1'b1;
        cpu_we   = 1'b1;
        cpu_data = 8'h61;
        step();
        cpu_data = 8'h62;
        step();
        cpu_we = 1'b0;
        check("t5_wr1",  uart_wr_o,  1);
        check("t5_dat1", uart_dat_o, 8'h61);
        check("t5_cnt1", fifo_count, 1);
        step();
        tx_en = 1'b0;
        nstr  = 0;
        for (int c = 0; c < 15; c++) begin
            step();
            if (uart_wr_o) nstr++;
        end
        check("t5_held_nostrobe", nstr, 0);
        check("t5_held_cnt",  fifo_count, 1);
        check("t5_held_busy", busy, 1);
        check("t5_held_dat",  uart_dat_o, 8'h61);
        tx_en = 1'b1;
        step();
        check("t5_wr2",  uart_wr_o,  1);
        check("t5_dat2", uart_dat_o, 8'h62);
        check("t5_cnt2", fifo_count, 0);

        // Reset in the middle of a GAP with bytes queued
        rst_pulse();
        tx_en  = 1'b1;
        cpu_we = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_data = 8'(i + 1);
            step();
        end
        cpu_we = 1'b0;
        check("t6_cnt3", fifo_count, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_cnt",  fifo_count, 0);
        check("t6_ovf",  cpu_ovf,    0);
        check("t6_wr",   uart_wr_o,  0);
        check("t6_busy", busy,       0);
        check("t6_dat",  uart_dat_o, 0);
        nstr = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (uart_wr_o) nstr++;
        end
        check("t6_nostrobe", nstr, 0);

        // Monitor request withdrawn before any grant
        tx_en     = 1'b0;
        mon_valid = 1'b1;
        mon_data  = 8'h99;
        step();
        check("t7_busy_req", busy, 1);
        step();
        mon_valid = 1'b0;
        step();
        tx_en = 1'b1;
        nstr  = 0;
        nmr   = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (uart_wr_o) nstr++;
            if (mon_ready) nmr++;
        end
        check("t7_nostrobe", nstr, 0);
        check("t7_nomrdy",   nmr,  0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
